// File: rtl/nx_fifo_pkg.sv
// nx_fifo_pkg: shared width helpers and DEPTH legality check
// for the programmable FIFO controller.
package nx_fifo_pkg;

  function automatic int aw_of(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  function automatic int cw_of(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic bit depth_ok(input int depth);
    return (depth >= 2) && (depth <= 1024);
  endfunction

endpackage

// File: rtl/nx_wrap_ptr.sv
// nx_wrap_ptr: pointer register that wraps DEPTH-1 -> 0.
// Ports: clk, rst_n, clr (sync flush), inc (advance), ptr.
module nx_wrap_ptr
  import nx_fifo_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = aw_of(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc,
  output logic [AW-1:0] ptr
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [AW-1:0] r_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (clr) begin
      r_ptr <= '0;
    end else if (inc) begin
      // explicit wrap: DEPTH need not be a power of two
      r_ptr <= (r_ptr == LAST) ? '0 : r_ptr + AW'(1);
    end
  end

  assign ptr = r_ptr;

endmodule

// File: rtl/nx_fifo_ctrl_prog.sv
// nx_fifo_ctrl_prog: FIFO control with pointers, counts, flags,
// programmable watermarks, sticky errors and high-water mark.
// Ports: clk, rst_n, wen, ren, clear, af/ae_thresh, err_clr,
// hwm_clr in; accepts, ptrs, counts, flags, errors, hwm out.
module nx_fifo_ctrl_prog
  import nx_fifo_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = aw_of(DEPTH),
  localparam int CW    = cw_of(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wen,
  input  logic          ren,
  input  logic          clear,
  input  logic [CW-1:0] af_thresh,
  input  logic [CW-1:0] ae_thresh,
  input  logic          err_clr,
  input  logic          hwm_clr,
  output logic          wr_accept,
  output logic          rd_accept,
  output logic [AW-1:0] wptr,
  output logic [AW-1:0] rptr,
  output logic [CW-1:0] used_slots,
  output logic [CW-1:0] free_slots,
  output logic          empty,
  output logic          full,
  output logic          almost_empty,
  output logic          almost_full,
  output logic          overflow,
  output logic          underflow,
  output logic          overflow_err,
  output logic          underflow_err,
  output logic [CW-1:0] hwm
);

  if (!depth_ok(DEPTH)) begin : g_bad_depth
    $error("nx_fifo_ctrl_prog: DEPTH must be 2..1024");
  end

  localparam logic [CW-1:0] DEP = CW'(DEPTH);

  logic [CW-1:0] r_used;
  logic [CW-1:0] r_free;
  logic          r_empty;
  logic          r_full;
  logic          r_ae;
  logic          r_af;
  logic          r_oerr;
  logic          r_uerr;
  logic [CW-1:0] r_hwm;

  logic          w_wr_acc;
  logic          w_rd_acc;
  logic          w_ovf;
  logic          w_udf;
  logic [CW-1:0] w_used_next;

  assign w_wr_acc = wen & ~r_full;
  assign w_rd_acc = ren & ~r_empty;
  assign w_ovf    = wen & r_full;
  assign w_udf    = ren & r_empty;

  always_comb begin
    w_used_next = r_used;
    if (clear) begin
      w_used_next = '0;
    end else begin
      w_used_next = r_used + CW'(w_wr_acc) - CW'(w_rd_acc);
    end
  end

  nx_wrap_ptr #(.DEPTH(DEPTH), .AW(AW)) u_wptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clear),
    .inc   (w_wr_acc),
    .ptr   (wptr)
  );

  nx_wrap_ptr #(.DEPTH(DEPTH), .AW(AW)) u_rptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clear),
    .inc   (w_rd_acc),
    .ptr   (rptr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_used  <= '0;
      r_free  <= DEP;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
      r_ae    <= 1'b1;
      r_af    <= 1'b0;
    end else if (clear) begin
      r_used  <= '0;
      r_free  <= DEP;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
      r_ae    <= 1'b1;
      r_af    <= 1'b0;
    end else begin
      r_used  <= w_used_next;
      r_free  <= DEP - w_used_next;
      r_empty <= (w_used_next == '0);
      r_full  <= (w_used_next == DEP);
      r_ae    <= (w_used_next <= ae_thresh);
      r_af    <= (w_used_next >= af_thresh);
    end
  end

  // set beats clear when both land in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_oerr <= 1'b0;
      r_uerr <= 1'b0;
    end else begin
      r_oerr <= w_ovf | (r_oerr & ~err_clr);
      r_uerr <= w_udf | (r_uerr & ~err_clr);
    end
  end

  // hwm_clr restarts from current occupancy, not zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hwm <= '0;
    end else if (hwm_clr) begin
      r_hwm <= w_used_next;
    end else if (w_used_next > r_hwm) begin
      r_hwm <= w_used_next;
    end
  end

  assign wr_accept     = w_wr_acc;
  assign rd_accept     = w_rd_acc;
  assign used_slots    = r_used;
  assign free_slots    = r_free;
  assign empty         = r_empty;
  assign full          = r_full;
  assign almost_empty  = r_ae;
  assign almost_full   = r_af;
  assign overflow      = w_ovf;
  assign underflow     = w_udf;
  assign overflow_err  = r_oerr;
  assign underflow_err = r_uerr;
  assign hwm           = r_hwm;

endmodule

// File: tb/tb_nx_fifo_ctrl_prog.sv
// tb_nx_fifo_ctrl_prog: three controllers (DEPTH 5, 1024, 4)
// against an occupancy-level model, plus directed literal checks.
module tb_nx_fifo_ctrl_prog;

  typedef struct {
    int used, wp, rp, oe, ue, hwm, e, f, ae, af;
  } mst_t;

  int dep [3] = '{5, 1024, 4};
  int n_chk = 0;
  int n_err = 0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic wen = 0, ren = 0, clear = 0, err_clr = 0, hwm_clr = 0;

  always #5 clk = ~clk;

  logic [2:0]  afa = 3'd4, aea = 3'd1;
  logic [10:0] afb = 11'd1000, aeb = 11'd24;
  logic [2:0]  afc = 3'd3, aec = 3'd1;

  logic wra, rda, ema, fua, aeva, afva, ova, una, oea, uea;
  logic [2:0] wpa, rpa, usa, fra, hwa;
  logic wrb, rdb, emb, fub, aevb, afvb, ovb, unb, oeb, ueb;
  logic [9:0] wpb, rpb;
  logic [10:0] usb, frb, hwb;
  logic wrc, rdc, emc, fuc, aevc, afvc, ovc, unc, oec, uec;
  logic [1:0] wpc, rpc;
  logic [2:0] usc, frc, hwc;

  nx_fifo_ctrl_prog #(.DEPTH(5)) u_a (
    .clk(clk), .rst_n(rst_n), .wen(wen), .ren(ren),
    .clear(clear), .af_thresh(afa), .ae_thresh(aea),
    .err_clr(err_clr), .hwm_clr(hwm_clr),
    .wr_accept(wra), .rd_accept(rda), .wptr(wpa), .rptr(rpa),
    .used_slots(usa), .free_slots(fra), .empty(ema),
    .full(fua), .almost_empty(aeva), .almost_full(afva),
    .overflow(ova), .underflow(una), .overflow_err(oea),
    .underflow_err(uea), .hwm(hwa));

  nx_fifo_ctrl_prog #(.DEPTH(1024)) u_b (
    .clk(clk), .rst_n(rst_n), .wen(wen), .ren(ren),
    .clear(clear), .af_thresh(afb), .ae_thresh(aeb),
    .err_clr(err_clr), .hwm_clr(hwm_clr),
    .wr_accept(wrb), .rd_accept(rdb), .wptr(wpb), .rptr(rpb),
    .used_slots(usb), .free_slots(frb), .empty(emb),
    .full(fub), .almost_empty(aevb), .almost_full(afvb),
    .overflow(ovb), .underflow(unb), .overflow_err(oeb),
    .underflow_err(ueb), .hwm(hwb));

  nx_fifo_ctrl_prog #(.DEPTH(4)) u_c (
    .clk(clk), .rst_n(rst_n), .wen(wen), .ren(ren),
    .clear(clear), .af_thresh(afc), .ae_thresh(aec),
    .err_clr(err_clr), .hwm_clr(hwm_clr),
    .wr_accept(wrc), .rd_accept(rdc), .wptr(wpc), .rptr(rpc),
    .used_slots(usc), .free_slots(frc), .empty(emc),
    .full(fuc), .almost_empty(aevc), .almost_full(afvc),
    .overflow(ovc), .underflow(unc), .overflow_err(oec),
    .underflow_err(uec), .hwm(hwc));

  int q_wr [3], q_rd [3], q_wp [3], q_rp [3], q_us [3];
  int q_fr [3], q_em [3], q_fu [3], q_ae [3], q_af [3];
  int q_ov [3], q_un [3], q_oe [3], q_ue [3], q_hw [3];
  int th_af [3], th_ae [3];

  assign q_wr = '{int'(wra), int'(wrb), int'(wrc)};
  assign q_rd = '{int'(rda), int'(rdb), int'(rdc)};
  assign q_wp = '{int'(wpa), int'(wpb), int'(wpc)};
  assign q_rp = '{int'(rpa), int'(rpb), int'(rpc)};
  assign q_us = '{int'(usa), int'(usb), int'(usc)};
  assign q_fr = '{int'(fra), int'(frb), int'(frc)};
  assign q_em = '{int'(ema), int'(emb), int'(emc)};
  assign q_fu = '{int'(fua), int'(fub), int'(fuc)};
  assign q_ae = '{int'(aeva), int'(aevb), int'(aevc)};
  assign q_af = '{int'(afva), int'(afvb), int'(afvc)};
  assign q_ov = '{int'(ova), int'(ovb), int'(ovc)};
  assign q_un = '{int'(una), int'(unb), int'(unc)};
  assign q_oe = '{int'(oea), int'(oeb), int'(oec)};
  assign q_ue = '{int'(uea), int'(ueb), int'(uec)};
  assign q_hw = '{int'(hwa), int'(hwb), int'(hwc)};
  assign th_af = '{int'(afa), int'(afb), int'(afc)};
  assign th_ae = '{int'(aea), int'(aeb), int'(aec)};

  // ---- reference model: occupancy arithmetic ----
  function automatic mst_t m_reset();
    mst_t s;
    s = '{0, 0, 0, 0, 0, 0, 1, 0, 1, 0};
    return s;
  endfunction

  function automatic mst_t m_step(mst_t s, int d, int af, int ae,
                                  logic w, logic r, logic c,
                                  logic ec, logic hc);
    mst_t n;
    int wa, ra, nu;
    n  = s;
    wa = (w && s.used != d) ? 1 : 0;
    ra = (r && s.used != 0) ? 1 : 0;
    nu = c ? 0 : s.used + wa - ra;
    n.oe = (w && s.used == d) || (s.oe != 0 && !ec);
    n.ue = (r && s.used == 0) || (s.ue != 0 && !ec);
    n.hwm = hc ? nu : ((nu > s.hwm) ? nu : s.hwm);
    if (c) begin
      n.used = 0; n.wp = 0; n.rp = 0;
      n.e = 1; n.f = 0; n.ae = 1; n.af = 0;
    end else begin
      n.used = nu;
      n.wp = (s.wp + wa) % d;
      n.rp = (s.rp + ra) % d;
      n.e = (nu == 0);
      n.f = (nu == d);
      n.ae = (nu <= ae);
      n.af = (nu >= af);
    end
    return n;
  endfunction

  mst_t m [3];

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) m[i] <= m_reset();
      else m[i] <= m_step(m[i], dep[i], th_af[i], th_ae[i],
                          wen, ren, clear, err_clr, hwm_clr);
    end
  end

  task automatic cmp(input string nm, input int i,
                     input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s depth=%0d got=%0d expected=%0d t=%0t",
               nm, dep[i], act, exp, $time);
    end
  endtask

  // ---- per-cycle compare ----
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 3; i++) begin
        cmp("wr_accept", i, q_wr[i], int'(wen && m[i].f == 0));
        cmp("rd_accept", i, q_rd[i], int'(ren && m[i].e == 0));
        cmp("overflow", i, q_ov[i], int'(wen && m[i].f != 0));
        cmp("underflow", i, q_un[i], int'(ren && m[i].e != 0));
        cmp("wptr", i, q_wp[i], m[i].wp);
        cmp("rptr", i, q_rp[i], m[i].rp);
        cmp("used", i, q_us[i], m[i].used);
        cmp("used+free", i, q_us[i] + q_fr[i], dep[i]);
        cmp("empty", i, q_em[i], m[i].e);
        cmp("full", i, q_fu[i], m[i].f);
        cmp("almost_empty", i, q_ae[i], m[i].ae);
        cmp("almost_full", i, q_af[i], m[i].af);
        cmp("overflow_err", i, q_oe[i], m[i].oe);
        cmp("underflow_err", i, q_ue[i], m[i].ue);
        cmp("hwm", i, q_hw[i], m[i].hwm);
      end
    end
  end

  task automatic cyc(input logic w, input logic r, input logic c,
                     input logic ec, input logic hc);
    wen = w; ren = r; clear = c; err_clr = ec; hwm_clr = hc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    // reset values, DEPTH=5
    cmp("rst used", 0, q_us[0], 0);
    cmp("rst free", 0, q_fr[0], 5);
    cmp("rst empty", 0, q_em[0], 1);
    cmp("rst full", 0, q_fu[0], 0);
    cmp("rst ae", 0, q_ae[0], 1);
    cmp("rst af", 0, q_af[0], 0);
    cmp("rst hwm", 0, q_hw[0], 0);
    // fill DEPTH=5, thresholds 4/1
    for (int k = 1; k <= 5; k++) begin
      cyc(1, 0, 0, 0, 0);
      cmp("fill used", 0, q_us[0], k);
      cmp("fill af", 0, q_af[0], (k >= 4) ? 1 : 0);
      cmp("fill full", 0, q_fu[0], (k == 5) ? 1 : 0);
    end
    cmp("wptr wrap", 0, q_wp[0], 0);
    wen = 1; #1;
    cmp("ovf pulse", 0, q_ov[0], 1);
    cmp("ovf wr_acc", 0, q_wr[0], 0);
    cyc(1, 0, 0, 0, 0);
    cmp("ovf used", 0, q_us[0], 5);
    cmp("ovf err", 0, q_oe[0], 1);
    // simultaneous at full
    cyc(1, 1, 0, 0, 0);
    cmp("wr+rd@full used", 0, q_us[0], 4);
    cmp("wr+rd@full rptr", 0, q_rp[0], 1);
    cmp("wr+rd@full wptr", 0, q_wp[0], 0);
    cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    cmp("wr+rd used", 0, q_us[0], 4);
    cmp("wr+rd wptr", 0, q_wp[0], 2);
    cmp("wr+rd rptr", 0, q_rp[0], 3);
    repeat (4) cyc(0, 1, 0, 0, 0);
    cmp("drain empty", 0, q_em[0], 1);
    cmp("drain rptr", 0, q_rp[0], 2);
    // underflow
    ren = 1; #1;
    cmp("udf pulse", 0, q_un[0], 1);
    cyc(0, 1, 0, 0, 0);
    cmp("udf err", 0, q_ue[0], 1);
    cmp("udf rptr", 0, q_rp[0], 2);
    cyc(0, 1, 0, 1, 0);
    cmp("udf set wins", 0, q_ue[0], 1);
    cyc(0, 0, 0, 1, 0);
    cmp("udf cleared", 0, q_ue[0], 0);
    cmp("ovf cleared", 0, q_oe[0], 0);
    // clear and hwm
    cyc(0, 0, 0, 0, 1);
    cmp("hwm clr empty", 0, q_hw[0], 0);
    repeat (3) cyc(1, 0, 0, 0, 0);
    cmp("hwm 3", 0, q_hw[0], 3);
    cyc(1, 0, 1, 0, 0);
    cmp("clr used", 0, q_us[0], 0);
    cmp("clr empty", 0, q_em[0], 1);
    cmp("clr wptr", 0, q_wp[0], 0);
    cmp("clr hwm", 0, q_hw[0], 3);
    cyc(0, 0, 0, 0, 1);
    cmp("hwm_clr", 0, q_hw[0], 0);
    // async reset mid-burst, DEPTH=4
    cyc(0, 0, 1, 0, 0);
    repeat (3) cyc(1, 0, 0, 0, 0);
    cmp("d4 used 3", 2, q_us[2], 3);
    wen = 1;
    #2 rst_n = 1'b0;
    #1;
    cmp("arst wptr", 2, q_wp[2], 0);
    cmp("arst used", 2, q_us[2], 0);
    cmp("arst free", 2, q_fr[2], 4);
    cmp("arst empty", 2, q_em[2], 1);
    cmp("arst ae", 2, q_ae[2], 1);
    cmp("arst hwm", 2, q_hw[2], 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    // random traffic, biased fill/drain phases
    for (int c = 0; c < 20000; c++) begin
      int pw, pr;
      pw = ((c / 3000) % 2 == 0) ? 80 : 20;
      pr = 100 - pw;
      if (c % 997 == 0) begin
        afa = 3'($urandom_range(7)); aea = 3'($urandom_range(7));
        afc = 3'($urandom_range(7)); aec = 3'($urandom_range(7));
      end
      cyc($urandom_range(99) < pw, $urandom_range(99) < pr,
          $urandom_range(3999) == 0, $urandom_range(49) == 0,
          $urandom_range(199) == 0);
    end
    cyc(0, 0, 0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
